// File: rtl/sprite_pixel_arbiter.sv
// sprite_pixel_arbiter: eight-slot sprite line buffer that selects and registers
// the frontmost opaque sprite pixel for each rendered column.
// Optional build macro SPRITE_LEFT_CLIP_EN adds the showLeftSprites input,
// which blanks sprite output for columns 0-7 while leaving the slots advancing.
module sprite_pixel_arbiter (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       clock_EN,
    input  logic       lineStart,
    input  logic       render_EN,
    input  logic       load_EN,
    input  logic [2:0] load_slot,
    input  logic [7:0] load_patternLo,
    input  logic [7:0] load_patternHi,
    input  logic [7:0] load_attr,
    input  logic [7:0] load_x,
    input  logic       load_isSprite0,
`ifdef SPRITE_LEFT_CLIP_EN
    input  logic       showLeftSprites,
`endif
    output logic [5:0] spritePixel
);

    logic       slot_active  [8];
    logic [7:0] slot_x       [8];
    logic [7:0] slot_lo      [8];
    logic [7:0] slot_hi      [8];
    logic [1:0] slot_pal     [8];
    logic       slot_prio    [8];
    logic       slot_sprite0 [8];

    logic [7:0] col_cnt;
    logic       render_cycle;
    logic       left_clip;
    logic [5:0] sel_pixel;
    logic       sel_found;
    logic       unused_bits;

    assign render_cycle = clock_EN && render_EN;

`ifdef SPRITE_LEFT_CLIP_EN
    assign left_clip   = !showLeftSprites && (col_cnt < 8'd8);
    assign unused_bits = ^{load_attr[7], load_attr[4:2]};
`else
    assign left_clip   = 1'b0;
    assign unused_bits = ^{load_attr[7], load_attr[4:2], col_cnt};
`endif

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        for (int unsigned i = 0; i < 8; i++) begin
            bit_rev[i] = v[7 - i];
        end
    endfunction

    // Pick the lowest-index opaque slot; equal X values resolve by index alone
    always_comb begin
        sel_found = 1'b0;
        sel_pixel = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!sel_found && slot_active[i] && (slot_x[i] == 8'd0) &&
                (slot_hi[i][7] || slot_lo[i][7])) begin
                sel_found = 1'b1;
                sel_pixel = {((i == 0) && slot_sprite0[i]), slot_prio[i],
                             slot_pal[i], slot_hi[i][7], slot_lo[i][7]};
            end
        end
    end

    // Slot storage: a load beats lineStart clearing and the per-column advance
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            for (int unsigned i = 0; i < 8; i++) begin
                slot_active[i]  <= 1'b0;
                slot_x[i]       <= '0;
                slot_lo[i]      <= '0;
                slot_hi[i]      <= '0;
                slot_pal[i]     <= '0;
                slot_prio[i]    <= 1'b0;
                slot_sprite0[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (load_EN && (32'(load_slot) == i)) begin
                    slot_active[i]  <= 1'b1;
                    slot_x[i]       <= load_x;
                    slot_lo[i]      <= load_attr[6] ? bit_rev(load_patternLo) : load_patternLo;
                    slot_hi[i]      <= load_attr[6] ? bit_rev(load_patternHi) : load_patternHi;
                    slot_pal[i]     <= load_attr[1:0];
                    slot_prio[i]    <= load_attr[5];
                    slot_sprite0[i] <= load_isSprite0;
                end else if (lineStart) begin
                    slot_active[i] <= 1'b0;
                end else if (render_cycle && slot_active[i]) begin
                    if (slot_x[i] != 8'd0) begin
                        slot_x[i] <= slot_x[i] - 8'd1;
                    end else begin
                        slot_lo[i] <= {slot_lo[i][6:0], 1'b0};
                        slot_hi[i] <= {slot_hi[i][6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Registered pixel output and saturating column counter
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            spritePixel <= '0;
            col_cnt     <= '0;
        end else begin
            if (clock_EN) begin
                spritePixel <= (render_EN && !left_clip) ? sel_pixel : 6'd0;
            end
            if (lineStart) begin
                col_cnt <= '0;
            end else if (render_cycle && (col_cnt != 8'hFF)) begin
                col_cnt <= col_cnt + 8'd1;
            end
        end
    end

endmodule
